// File: rtl/ir_pkg.sv
// ir_pkg: NEC command codes, display mode encodings and dispatcher FSM state
package ir_pkg;
  localparam logic [7:0] CMD_POWER  = 8'h80;
  localparam logic [7:0] CMD_CH_DN  = 8'h38;
  localparam logic [7:0] CMD_CH_UP  = 8'h18;
  localparam logic [7:0] CMD_VOL_DN = 8'h08;
  localparam logic [7:0] CMD_VOL_UP = 8'h30;
  localparam logic [7:0] CMD_MENU   = 8'h50;
  localparam logic [7:0] CMD_NUM1   = 8'hA8;
  localparam logic [7:0] CMD_NUM2   = 8'h68;
  localparam logic [7:0] CMD_NUM3   = 8'hE8;
  localparam logic [1:0] DISP_BLANK = 2'd0;
  localparam logic [1:0] DISP_CH    = 2'd1;
  localparam logic [1:0] DISP_VOL   = 2'd2;
  typedef enum logic {IDLE, HELD} state_t;
endpackage

// File: rtl/ir_hold_timer.sv
// ir_hold_timer: key-release timeout, expires after CYCLES enabled cycles since the last clear
module ir_hold_timer #(
  parameter int CYCLES = 6_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  assign expired = en && !clr && cnt == W'(CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr || !en || expired) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/ir_cmd_dispatcher.sv
// ir_cmd_dispatcher: NEC frame/repeat to power, channel, volume and display control
// Define IRC_INV_CHECK_EN to also require valid inverted address/command bytes.
module ir_cmd_dispatcher
  import ir_pkg::*;
#(
  parameter int         CLK_FREQ       = 50_000_000,
  parameter logic [7:0] DEV_ADDR       = 8'h4D,
  parameter int         REL_TIMEOUT_MS = 120,
  parameter int         REP_SKIP       = 3,
  parameter int         CH_MAX         = 99,
  parameter int         VOL_MAX        = 63
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        frame_vld,
  input  logic [31:0] frame_data,
  input  logic        repeat_vld,
  output logic        power_on,
  output logic [6:0]  channel,
  output logic [5:0]  volume,
  output logic [6:0]  disp_num,
  output logic [1:0]  disp_mode,
  output logic        frame_err
);
  localparam longint TO_L = longint'(REL_TIMEOUT_MS) * longint'(CLK_FREQ) / longint'(1000);
  localparam int TO_CYC = int'(TO_L);
  localparam int RW = $clog2(REP_SKIP + 2);
  localparam logic [6:0] CH_TOP = 7'(CH_MAX);
  localparam logic [5:0] VOL_TOP = 6'(VOL_MAX);
  state_t state;
  logic [7:0] cmd, cmd_lat, act_cmd;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic addr_ok, new_frame, rep_go, rep_act, act, expired;
  logic pw_n;
  logic [6:0] ch_n;
  logic [5:0] vol_n;
  logic [1:0] mode_n;
  assign cmd = frame_data[23:16];
`ifdef IRC_INV_CHECK_EN
  assign addr_ok = frame_data[7:0] == DEV_ADDR && frame_data[15:8] == ~frame_data[7:0]
                   && frame_data[31:24] == ~cmd;
`else
  logic unused_inv;
  assign unused_inv = ^{frame_data[31:24], frame_data[15:8]};
  assign addr_ok = frame_data[7:0] == DEV_ADDR;
`endif
  assign new_frame = frame_vld && addr_ok;
  assign rep_go = repeat_vld && !frame_vld && state == HELD;
  assign rep_nxt = &rep_cnt ? rep_cnt : rep_cnt + 1'b1;
  // Only stepping keys auto-repeat, and only once the skip count is exceeded
  assign rep_act = rep_go && 32'(rep_nxt) > REP_SKIP
                   && cmd_lat inside {CMD_CH_UP, CMD_CH_DN, CMD_VOL_UP, CMD_VOL_DN};
  assign act = new_frame || rep_act;
  assign act_cmd = new_frame ? cmd : cmd_lat;
  always_comb begin
    pw_n = power_on;
    ch_n = channel;
    vol_n = volume;
    mode_n = disp_mode;
    if (act && act_cmd == CMD_POWER) begin
      pw_n = !power_on;
      mode_n = power_on ? DISP_BLANK : DISP_CH;
    end else if (act && power_on) begin
      case (act_cmd)
        CMD_CH_UP:  begin ch_n = channel >= CH_TOP ? 7'd1 : channel + 7'd1; mode_n = DISP_CH; end
        CMD_CH_DN:  begin ch_n = channel <= 7'd1 ? CH_TOP : channel - 7'd1; mode_n = DISP_CH; end
        CMD_VOL_UP: begin vol_n = volume >= VOL_TOP ? VOL_TOP : volume + 6'd1; mode_n = DISP_VOL; end
        CMD_VOL_DN: begin vol_n = volume == 6'd0 ? 6'd0 : volume - 6'd1; mode_n = DISP_VOL; end
        CMD_MENU:   mode_n = disp_mode == DISP_CH ? DISP_VOL : DISP_CH;
        CMD_NUM1:   begin ch_n = 7'd1; mode_n = DISP_CH; end
        CMD_NUM2:   begin ch_n = 7'd2; mode_n = DISP_CH; end
        CMD_NUM3:   begin ch_n = 7'd3; mode_n = DISP_CH; end
        default: ;
      endcase
    end
  end
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      power_on <= 1'b0;
      channel <= 7'd1;
      volume <= 6'd20;
      disp_num <= '0;
      disp_mode <= DISP_BLANK;
      frame_err <= 1'b0;
      state <= IDLE;
      rep_cnt <= '0;
      cmd_lat <= '0;
    end else begin
      power_on <= pw_n;
      channel <= ch_n;
      volume <= vol_n;
      disp_mode <= mode_n;
      disp_num <= mode_n == DISP_CH ? ch_n : mode_n == DISP_VOL ? 7'(vol_n) : 7'd0;
      frame_err <= frame_vld && !addr_ok;
      if (new_frame) begin
        state <= HELD;
        cmd_lat <= cmd;
        rep_cnt <= '0;
      end else if (rep_go) rep_cnt <= rep_nxt;
      else if (expired) state <= IDLE;
    end
  ir_hold_timer #(.CYCLES(TO_CYC)) u_timer (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .en(state == HELD),
    .clr(new_frame || rep_go),
    .expired(expired)
  );
endmodule

// File: tb/tb_ir_cmd_dispatcher.sv
// tb_ir_cmd_dispatcher: directed vector table plus hold/timeout/reset sequences
module tb_ir_cmd_dispatcher;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, frame_vld = 1'b0, repeat_vld = 1'b0;
  logic [31:0] frame_data = '0;
  logic power_on, frame_err;
  logic [6:0] channel, disp_num;
  logic [5:0] volume;
  logic [1:0] disp_mode;
  int checks = 0, failures = 0;
  always #5 sys_clk = ~sys_clk;
  ir_cmd_dispatcher #(.CLK_FREQ(10_000)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_vld(frame_vld), .frame_data(frame_data),
    .repeat_vld(repeat_vld), .power_on(power_on), .channel(channel), .volume(volume),
    .disp_num(disp_num), .disp_mode(disp_mode), .frame_err(frame_err)
  );
  typedef struct {
    logic fv; logic [31:0] d; logic rv;
    logic pw; int ch; int vol; int num; int mode; logic err;
  } vec_t;
  localparam int NV = 21;
  vec_t v[NV];
  function automatic logic [31:0] mk(logic [7:0] a, logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction
  task automatic chk(string nm, logic pw, int ch, int vol, int num, int mode, logic err);
    checks++;
    if (power_on !== pw || channel !== 7'(ch) || volume !== 6'(vol) || disp_num !== 7'(num)
        || disp_mode !== 2'(mode) || frame_err !== err) begin
      failures++;
      $display("FAIL %s: got pw=%0b ch=%0d vol=%0d num=%0d mode=%0d err=%0b want pw=%0b ch=%0d vol=%0d num=%0d mode=%0d err=%0b",
               nm, power_on, channel, volume, disp_num, disp_mode, frame_err, pw, ch, vol, num, mode, err);
    end
  endtask
  task automatic step(logic fv, logic [31:0] d, logic rv);
    @(negedge sys_clk);
    frame_vld = fv; frame_data = d; repeat_vld = rv;
    @(negedge sys_clk);
    frame_vld = 1'b0; repeat_vld = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic rst_pulse(string nm);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk(nm, 0, 1, 20, 0, 0, 0);
    sys_rst_n = 1'b1;
  endtask
  initial begin
    v[0]  = '{1, mk(8'h4D, 8'h80), 0, 1, 1, 20, 1, 1, 0};
    v[1]  = '{1, mk(8'h4D, 8'h18), 0, 1, 2, 20, 2, 1, 0};
    v[2]  = '{1, mk(8'h4D, 8'h18), 0, 1, 3, 20, 3, 1, 0};
    v[3]  = '{1, mk(8'h4D, 8'hE8), 0, 1, 3, 20, 3, 1, 0};
    v[4]  = '{1, mk(8'h4D, 8'h38), 0, 1, 2, 20, 2, 1, 0};
    v[5]  = '{1, mk(8'h4D, 8'h38), 0, 1, 1, 20, 1, 1, 0};
    v[6]  = '{1, mk(8'h4D, 8'h38), 0, 1, 99, 20, 99, 1, 0};
    v[7]  = '{1, mk(8'h4C, 8'h18), 0, 1, 99, 20, 99, 1, 1};
    v[8]  = '{1, mk(8'h4D, 8'h00), 0, 1, 99, 20, 99, 1, 0};
    v[9]  = '{1, mk(8'h4D, 8'h08), 0, 1, 99, 19, 19, 2, 0};
    v[10] = '{1, mk(8'h4D, 8'h50), 0, 1, 99, 19, 99, 1, 0};
    v[11] = '{1, mk(8'h4D, 8'h50), 0, 1, 99, 19, 19, 2, 0};
    v[12] = '{0, 32'h0, 1, 1, 99, 19, 19, 2, 0};
    v[13] = '{1, mk(8'h4D, 8'h30), 1, 1, 99, 20, 20, 2, 0};
    v[14] = '{1, mk(8'h4D, 8'h80), 0, 0, 99, 20, 0, 0, 0};
    v[15] = '{1, mk(8'h4D, 8'h30), 0, 0, 99, 20, 0, 0, 0};
    v[16] = '{1, mk(8'h4D, 8'h50), 0, 0, 99, 20, 0, 0, 0};
    v[17] = '{1, mk(8'h4D, 8'hA8), 0, 0, 99, 20, 0, 0, 0};
    v[18] = '{1, mk(8'h4D, 8'h80), 0, 1, 99, 20, 99, 1, 0};
    v[19] = '{1, mk(8'h4D, 8'hA8), 0, 1, 1, 20, 1, 1, 0};
    v[20] = '{1, mk(8'h4D, 8'h68), 0, 1, 2, 20, 2, 1, 0};
    idle(3);
    chk("reset", 0, 1, 20, 0, 0, 0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      step(v[i].fv, v[i].d, v[i].rv);
      chk($sformatf("vec%0d", i), v[i].pw, v[i].ch, v[i].vol, v[i].num, v[i].mode, v[i].err);
    end
    step(1, {8'h00, 8'h18, ~8'h4D, 8'h4D}, 0);
`ifdef IRC_INV_CHECK_EN
    chk("bad_inv", 1, 2, 20, 2, 1, 1);
`else
    chk("bad_inv", 1, 3, 20, 3, 1, 0);
`endif
    rst_pulse("rst_a");
    step(1, mk(8'h4D, 8'h80), 0);
    chk("a_pwr", 1, 1, 20, 1, 1, 0);
    step(1, mk(8'h4D, 8'h30), 0);
    chk("a_volup", 1, 1, 21, 21, 2, 0);
    for (int i = 1; i <= 6; i++) begin
      int e;
      idle(1078);
      step(0, 32'h0, 1);
      e = i > 3 ? 21 + i - 3 : 21;
      chk($sformatf("a_rep%0d", i), 1, 1, e, e, 2, 0);
    end
    step(1, mk(8'h4D, 8'h30), 0);
    chk("b_volup", 1, 1, 25, 25, 2, 0);
    idle(1300);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1);
    chk("b_late_rep", 1, 1, 25, 25, 2, 0);
    step(1, mk(8'h4D, 8'h30), 0);
    for (int i = 0; i < 50; i++) step(0, 32'h0, 1);
    chk("vol_sat_hi", 1, 1, 63, 63, 2, 0);
    step(1, mk(8'h4D, 8'h08), 0);
    for (int i = 0; i < 70; i++) step(0, 32'h0, 1);
    chk("vol_sat_lo", 1, 1, 0, 0, 2, 0);
    step(1, mk(8'h4D, 8'h50), 0);
    for (int i = 0; i < 6; i++) step(0, 32'h0, 1);
    chk("menu_no_rep", 1, 1, 0, 1, 1, 0);
    step(1, mk(8'h4D, 8'h30), 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1);
    chk("c_hold", 1, 1, 3, 3, 2, 0);
    rst_pulse("c_rst_mid_hold");
    step(1, mk(8'h4D, 8'h80), 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1);
    chk("c_pwr_no_rep", 1, 1, 20, 1, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
